// File: rtl/gsplat_req_responder.sv
// Memory-side responder for the requestor read/write port, backed by a windowed qword RAM with a host backdoor.
// Optional stall injection is compiled in with `define GSPLAT_REQ_RESP_STALL_EN.
module gsplat_req_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [28:0] BASE_QADDR = 29'h06080000,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [28:0]           rd_addr,
  input  logic [7:0]            rd_burstcnt,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic [63:0]           rd_data,
  output logic                  rd_data_valid,
  input  logic [28:0]           wr_addr,
  input  logic [7:0]            wr_burstcnt,
  input  logic [63:0]           wr_data,
  input  logic [7:0]            wr_be,
  input  logic                  wr_req,
  output logic                  wr_ack,
  output logic                  wr_busy,
  input  logic                  host_we,
  input  logic [DEPTH_LOG2-1:0] host_addr,
  input  logic [63:0]           host_wdata,
  output logic [63:0]           host_rdata,
  output logic                  addr_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, RD_LAT, RD_BURST, WR_BURST} state_t;

  logic [63:0]           mem [DEPTH];
  logic [1:0]            rst_sync_q;
  logic                  ready;
  state_t                state_q;
  logic [28:0]           addr_q;
  logic [7:0]            rem_q;
  logic                  rd_ack_q, rd_valid_q, wr_ack_q, wr_busy_q, wr_tail_q, addr_err_q;
  logic [63:0]           rd_data_q, host_rdata_q;
  logic [1:0]            rd_hold_q;
  logic [28:0]           off;
  logic                  in_win;
  logic [DEPTH_LOG2-1:0] idx;
  logic [63:0]           rd_word;
  logic                  stall;
  logic                  wr_fire;

  function automatic logic [7:0] beats(input logic [7:0] bc);
    return (bc == 8'd0) ? 8'd1 : bc;
  endfunction

  // Release is re-timed so the FSM never sees a partial reset deassertion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign ready = rst_sync_q[1];

`ifdef GSPLAT_REQ_RESP_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   lfsr_q <= STALL_SEED;
    else if (ready) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = lfsr_q[0];
`else
  logic unused_seed;
  assign unused_seed = ^STALL_SEED;
  assign stall = 1'b0;
`endif

  assign off     = addr_q - BASE_QADDR;
  assign in_win  = (off >> DEPTH_LOG2) == 29'd0;
  assign idx     = off[DEPTH_LOG2-1:0];
  assign rd_word = in_win ? mem[idx] : 64'd0;
  // A beat is never taken the cycle right after its ack: the requestor is still swapping data.
  assign wr_fire = (state_q == WR_BURST) && ready && wr_req && !wr_ack_q && !stall;

  always_ff @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_wdata;
    if (wr_fire && in_win) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) host_rdata_q <= 64'd0;
    else          host_rdata_q <= mem[host_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= 29'd0;
      rem_q      <= 8'd0;
      rd_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 64'd0;
      wr_ack_q   <= 1'b0;
      wr_busy_q  <= 1'b0;
      wr_tail_q  <= 1'b0;
      rd_hold_q  <= 2'd0;
      addr_err_q <= 1'b0;
    end else begin
      rd_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 64'd0;
      wr_ack_q   <= 1'b0;
      if (rd_hold_q != 2'd0) rd_hold_q <= rd_hold_q - 2'd1;
      if (ready) begin
        case (state_q)
          IDLE: begin
            wr_busy_q <= wr_tail_q;
            wr_tail_q <= 1'b0;
            if (!wr_busy_q && !wr_tail_q) begin
              if (wr_req) begin
                state_q <= WR_BURST;
                addr_q  <= wr_addr;
                rem_q   <= beats(wr_burstcnt);
              end else if (rd_req && (rd_hold_q == 2'd0) && !stall) begin
                state_q  <= RD_LAT;
                addr_q   <= rd_addr;
                rem_q    <= beats(rd_burstcnt);
                rd_ack_q <= 1'b1;
              end
            end
          end
          RD_LAT: begin
            if (!stall) state_q <= RD_BURST;
          end
          RD_BURST: begin
            if (!stall) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= rd_word;
              if (!in_win) addr_err_q <= 1'b1;
              addr_q <= addr_q + 29'd1;
              if (rem_q == 8'd1) begin
                state_q   <= IDLE;
                // Blind window so a requestor dropping rd_req late is not re-accepted.
                rd_hold_q <= 2'd2;
              end else begin
                rem_q <= rem_q - 8'd1;
              end
            end
          end
          WR_BURST: begin
            if (wr_fire) begin
              wr_ack_q  <= 1'b1;
              wr_busy_q <= 1'b1;
              if (!in_win) addr_err_q <= 1'b1;
              addr_q <= addr_q + 29'd1;
              if (rem_q == 8'd1) begin
                state_q   <= IDLE;
                wr_tail_q <= 1'b1;
              end else begin
                rem_q <= rem_q - 8'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rd_ack        = rd_ack_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign wr_ack        = wr_ack_q;
  assign wr_busy       = wr_busy_q;
  assign host_rdata    = host_rdata_q;
  assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_gsplat_req_responder.sv
// Scoreboard bench for gsplat_req_responder: a qword model predicts read beats, a negedge monitor pops and compares.
module tb_gsplat_req_responder;
  localparam logic [28:0] BASE = 29'h06080000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [28:0] rd_addr = '0;
  logic [7:0]  rd_burstcnt = '0;
  logic        rd_req = 1'b0;
  logic        rd_ack;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic [28:0] wr_addr = '0;
  logic [7:0]  wr_burstcnt = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_be = '0;
  logic        wr_req = 1'b0;
  logic        wr_ack;
  logic        wr_busy;
  logic        host_we = 1'b0;
  logic [9:0]  host_addr = '0;
  logic [63:0] host_wdata = '0;
  logic [63:0] host_rdata;
  logic        addr_err;

  gsplat_req_responder dut (
    .clk(clk), .reset_n(reset_n),
    .rd_addr(rd_addr), .rd_burstcnt(rd_burstcnt), .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .wr_addr(wr_addr), .wr_burstcnt(wr_burstcnt), .wr_data(wr_data), .wr_be(wr_be),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_busy(wr_busy),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [63:0] model [1024];
  logic [63:0] exp_q [$];

  int   cyc = 0;
  int   rd_ack_cnt = 0, wr_ack_cnt = 0, beat_cnt = 0, ack_wide = 0;
  int   last_rd_ack = 0, first_valid = 0, last_valid = 0;
  int   first_wack = 0, last_wack = 0, busy_rise = -1, busy_fall = -1;
  logic prev_rack = 1'b0, prev_wack = 1'b0, prev_busy = 1'b0;

  function automatic logic in_window(input logic [28:0] a);
    logic [28:0] o;
    o = a - BASE;
    return o < 29'd1024;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [28:0] a);
    logic [28:0] o;
    o = a - BASE;
    return in_window(a) ? model[o[9:0]] : 64'd0;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rd_ack) begin
      rd_ack_cnt++;
      last_rd_ack = cyc;
      if (prev_rack) ack_wide++;
    end
    if (wr_ack) begin
      wr_ack_cnt++;
      if (wr_ack_cnt == 1) first_wack = cyc;
      last_wack = cyc;
      if (prev_wack) ack_wide++;
    end
    if (wr_busy && !prev_busy) busy_rise = cyc;
    if (!wr_busy && prev_busy) busy_fall = cyc;
    if (rd_data_valid) begin
      beat_cnt++;
      if (beat_cnt == 1) first_valid = cyc;
      last_valid = cyc;
      if (exp_q.size() == 0) chk("rd_unexpected_beat", 64'(exp_q.size()), 64'(1));
      else                   chk("rd_data", rd_data, exp_q.pop_front());
    end else begin
      chk("rd_data_idle", rd_data, 64'd0);
    end
    prev_rack = rd_ack;
    prev_wack = wr_ack;
    prev_busy = wr_busy;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic read_finish(input int n, input int hold, input bit lat_chk, input int t_req);
    int g;
    g = 0;
    while (rd_ack_cnt == 0 && g < 300) begin tick(); g++; end
    chk("rd_ack_seen", 64'(rd_ack_cnt), 64'(1));
    for (int h = 0; h < hold; h++) tick();
    rd_req = 1'b0;
    g = 0;
    while (beat_cnt < n && g < 600) begin tick(); g++; end
    repeat (3) tick();
    chk("rd_beats", 64'(beat_cnt), 64'(n));
    chk("rd_ack_once", 64'(rd_ack_cnt), 64'(1));
`ifndef GSPLAT_REQ_RESP_STALL_EN
    if (lat_chk) begin
      chk("rd_ack_lat", 64'(last_rd_ack - t_req), 64'(1));
      chk("rd_valid_lat", 64'(first_valid - last_rd_ack), 64'(2));
      chk("rd_back_to_back", 64'(last_valid - first_valid), 64'(n - 1));
    end
`endif
  endtask

  task automatic do_read(input logic [28:0] a, input logic [7:0] bc, input int hold);
    int n;
    n = (bc == 8'd0) ? 1 : int'(bc);
    for (int j = 0; j < n; j++) exp_q.push_back(exp_rd(a + 29'(j)));
    rd_ack_cnt = 0;
    beat_cnt = 0;
    rd_addr = a;
    rd_burstcnt = bc;
    rd_req = 1'b1;
    read_finish(n, hold, 1'b1, cyc);
  endtask

  task automatic do_write(input logic [28:0] a, input logic [7:0] bc, input logic [7:0] be);
    int n, j, g;
    logic [63:0] d;
    logic [28:0] o;
    n = (bc == 8'd0) ? 1 : int'(bc);
    wr_ack_cnt = 0;
    busy_rise = -1;
    busy_fall = -1;
    d = {$urandom, $urandom};
    wr_addr = a;
    wr_burstcnt = bc;
    wr_be = be;
    wr_data = d;
    wr_req = 1'b1;
    j = 0;
    g = 0;
    while (j < n && g < 600) begin
      tick();
      g++;
      if (wr_ack_cnt > j) begin
        o = a + 29'(j) - BASE;
        if (in_window(a + 29'(j))) begin
          for (int b = 0; b < 8; b++) if (be[b]) model[o[9:0]][8*b +: 8] = d[8*b +: 8];
        end
        j++;
        d = {$urandom, $urandom};
        wr_data = d;
      end
    end
    wr_req = 1'b0;
    chk("wr_acks", 64'(wr_ack_cnt), 64'(n));
    g = 0;
    while (wr_busy && g < 20) begin tick(); g++; end
    chk("wr_busy_rise", 64'(busy_rise), 64'(first_wack));
    chk("wr_busy_fall", 64'(busy_fall), 64'(last_wack + 2));
  endtask

  initial begin
    logic [63:0] v;
    logic [63:0] old8;
    int g, rise_cyc;

    #2 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_rd_ack", 64'(rd_ack), 64'd0);
    chk("rst_rd_valid", 64'(rd_data_valid), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_wr_ack", 64'(wr_ack), 64'd0);
    chk("rst_wr_busy", 64'(wr_busy), 64'd0);
    chk("rst_addr_err", 64'(addr_err), 64'd0);
    chk("rst_host_rdata", host_rdata, 64'd0);
    reset_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 1024; i++) begin
      v = (i == 0) ? 64'h30400000_00001234 : {$urandom, $urandom};
      model[i] = v;
      host_addr = 10'(i);
      host_wdata = v;
      host_we = 1'b1;
      tick();
    end
    host_we = 1'b0;
    host_addr = 10'd5;
    tick();
    chk("host_rd_latency", host_rdata, model[5]);
    v = {$urandom, $urandom};
    host_addr = 10'd7;
    host_wdata = v;
    host_we = 1'b1;
    tick();
    chk("host_rd_old", host_rdata, model[7]);
    model[7] = v;
    host_we = 1'b0;
    tick();
    chk("host_rd_new", host_rdata, model[7]);

    do_read(BASE, 8'd1, 0);
    chk("addr_err_clean", 64'(addr_err), 64'd0);

    old8 = model[8];
    do_write(BASE + 29'd8, 8'd4, 8'h0F);
    do_read(BASE + 29'd8, 8'd4, 0);
    host_addr = 10'd8;
    tick();
    chk("be_upper_kept", {32'd0, host_rdata[63:32]}, {32'd0, old8[63:32]});

    do_read(BASE + 29'd30, 8'd0, 0);

    rd_ack_cnt = 0;
    beat_cnt = 0;
    rd_addr = BASE + 29'd20;
    rd_burstcnt = 8'd2;
    rd_req = 1'b1;
    do_write(BASE + 29'd20, 8'd2, 8'hFF);
    chk("rd_held_off", 64'(rd_ack_cnt), 64'd0);
    exp_q.push_back(exp_rd(BASE + 29'd20));
    exp_q.push_back(exp_rd(BASE + 29'd21));
    read_finish(2, 0, 1'b0, cyc);
    chk("rd_after_busy", 64'(last_rd_ack > busy_fall), 64'd1);

    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(BASE + 29'($urandom_range(0, 1015)), 8'($urandom_range(0, 8)), 8'($urandom));
      else
        do_read(BASE + 29'($urandom_range(0, 1015)), 8'($urandom_range(0, 8)), int'($urandom_range(0, 1)));
    end
    chk("addr_err_after_rand", 64'(addr_err), 64'd0);

    do_read(BASE + 29'd1024, 8'd2, 0);
    chk("addr_err_set", 64'(addr_err), 64'd1);
    do_write(BASE - 29'd1, 8'd2, 8'hFF);
    do_read(BASE, 8'd1, 0);
    do_read(BASE + 29'd100, 8'd3, 0);
    chk("addr_err_sticky", 64'(addr_err), 64'd1);

    for (int j = 0; j < 8; j++) exp_q.push_back(exp_rd(BASE + 29'd200 + 29'(j)));
    rd_ack_cnt = 0;
    beat_cnt = 0;
    rd_addr = BASE + 29'd200;
    rd_burstcnt = 8'd8;
    rd_req = 1'b1;
    g = 0;
    while (rd_ack_cnt == 0 && g < 300) begin tick(); g++; end
    tick();
    rd_req = 1'b0;
    g = 0;
    while (beat_cnt < 3 && g < 300) begin tick(); g++; end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rd_ack", 64'(rd_ack), 64'd0);
    chk("mid_rst_rd_valid", 64'(rd_data_valid), 64'd0);
    chk("mid_rst_rd_data", rd_data, 64'd0);
    chk("mid_rst_wr_ack", 64'(wr_ack), 64'd0);
    chk("mid_rst_wr_busy", 64'(wr_busy), 64'd0);
    chk("mid_rst_addr_err", 64'(addr_err), 64'd0);
    chk("mid_rst_host_rdata", host_rdata, 64'd0);
    exp_q.delete();
    repeat (4) tick();
    chk("mid_rst_beats", 64'(beat_cnt), 64'd3);
    chk("mid_rst_acks", 64'(rd_ack_cnt), 64'd1);

    for (int j = 0; j < 4; j++) exp_q.push_back(exp_rd(BASE + 29'd8 + 29'(j)));
    rd_ack_cnt = 0;
    beat_cnt = 0;
    rd_addr = BASE + 29'd8;
    rd_burstcnt = 8'd4;
    rd_req = 1'b1;
    reset_n = 1'b1;
    rise_cyc = cyc;
    read_finish(4, 0, 1'b0, cyc);
    chk("rst_release_accept", 64'(last_rd_ack - rise_cyc >= 2), 64'd1);

    chk("ack_single_cycle", 64'(ack_wide), 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
